// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: memory geometry, frame marker and loader states.
package prog_loader_pkg;

    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned INSTR_W = 14;
    localparam int unsigned BYTE_W  = 8;

    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CNT_H,
        ST_CNT_L,
        ST_W_HI,
        ST_W_LO,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: packs 14-bit words into program memory and holds the CPU
// in reset until a frame is loaded with a matching checksum. State moves on the falling edge.
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [BYTE_W-1:0]  in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_rst,
    output logic               load_done,
    output logic               load_err
);

    state_e              state_q,   state_d;
    logic [ADDR_W-1:0]   cnt_q,     cnt_d;
    logic [2:0]          cnth_q,    cnth_d;
    logic [5:0]          hi_q,      hi_d;
    logic [BYTE_W-1:0]   chk_q,     chk_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [INSTR_W-1:0]  wdata_q,   wdata_d;
    logic                we_q,      we_d;
    logic                ready_q,   ready_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q,    done_d;
    logic                err_q,     err_d;
    logic                accept;
    logic                sync_hit;
    logic [ADDR_W-1:0]   cnt_rx;

    always_comb begin
        accept   = in_valid & ready_q;
        sync_hit = accept && (in_data == SYNC_BYTE);
        cnt_rx   = ADDR_W'({cnth_q, in_data});
    end

    // Next-state and next-output logic; strobes default low, ready defaults high.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cnth_d    = cnth_q;
        hi_d      = hi_q;
        chk_d     = chk_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        ready_d   = 1'b1;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (sync_hit) begin
                    state_d   = ST_CNT_H;
                    cpu_rst_d = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    addr_d    = '0;
                    chk_d     = '0;
                end
            end
            ST_CNT_H: begin
                if (accept) begin
                    if (in_data[7:3] != 5'd0) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        cnth_d  = in_data[2:0];
                        state_d = ST_CNT_L;
                    end
                end
            end
            ST_CNT_L: begin
                if (accept) begin
                    cnt_d   = cnt_rx;
                    state_d = (cnt_rx == '0) ? ST_CHK : ST_W_HI;
                end
            end
            ST_W_HI: begin
                if (accept) begin
                    if (in_data[7:6] != 2'd0) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        hi_d    = in_data[5:0];
                        chk_d   = chk_q ^ in_data;
                        state_d = ST_W_LO;
                    end
                end
            end
            ST_W_LO: begin
                if (accept) begin
                    wdata_d = {hi_q, in_data};
                    chk_d   = chk_q ^ in_data;
                    we_d    = 1'b1;
                    ready_d = 1'b0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                cnt_d   = cnt_q - ADDR_W'(1);
                state_d = (cnt_q == ADDR_W'(1)) ? ST_CHK : ST_W_HI;
            end
            ST_CHK: begin
                if (accept) begin
                    if (in_data == chk_q) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cnth_q    <= '0;
            hi_q      <= '0;
            chk_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            ready_q   <= 1'b1;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cnth_q    <= cnth_d;
            hi_q      <= hi_d;
            chk_q     <= chk_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            ready_q   <= ready_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        in_ready  = ready_q;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        cpu_rst   = cpu_rst_q;
        load_done = done_q;
        load_err  = err_q;
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: expected memory writes are queued as bytes are sent
// and checked against the write port on every rising edge.
module tb_prog_loader;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [13:0] mem_wdata;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;

    int tests;
    int fails;

    logic [24:0] exp_q[$];
    logic [10:0] exp_addr;
    logic [7:0]  chk_acc;

    prog_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One rising edge; any write strobe seen here is checked against the scoreboard.
    task automatic tick();
        logic [24:0] exp;
        @(posedge clk);
        if (mem_we === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                exp = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== exp) begin
                    fails++;
                    $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, exp[24:14], exp[13:0]);
                end
            end
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL ready_in_write: in_ready=%b, required 0", in_ready);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            tick();
            in_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic start_frame(input logic [10:0] n, input int gap);
        send_byte(8'hA5, gap);
        send_byte({5'd0, n[10:8]}, gap);
        send_byte(n[7:0], gap);
        exp_addr = '0;
        chk_acc  = '0;
    endtask

    task automatic send_word(input logic [7:0] hi, input logic [7:0] lo, input int gap);
        send_byte(hi, gap);
        exp_q.push_back({exp_addr, hi[5:0], lo});
        exp_addr = exp_addr + 11'd1;
        chk_acc  = chk_acc ^ hi ^ lo;
        send_byte(lo, gap);
    endtask

    task automatic frame_one(input int gap);
        start_frame(11'd2, gap);
        send_word(8'h30, 8'h05, gap);
        send_word(8'h3E, 8'h03, gap);
        send_byte(chk_acc, gap);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        tests++;
        if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 11'd0 || mem_wdata !== 14'd0 ||
            cpu_rst !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: rdy=%b we=%b addr=%h data=%h rst=%b done=%b err=%b, required 1 0 0 0 1 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, load_done, load_err);
        end
        reset_n = 1'b1;
        tick();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        tests++;
        if (cpu_rst !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL idle_noise: rst=%b done=%b err=%b, required 1 0 0", cpu_rst, load_done, load_err);
        end
    endtask

    task automatic test_frame_ok();
        frame_one(0);
        tests++;
        if (load_done !== 1'b1 || cpu_rst !== 1'b0 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL frame_ok_status: done=%b rst=%b err=%b, required 1 0 0", load_done, cpu_rst, load_err);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL frame_ok_writes: %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_zero_count();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        tests++;
        if (load_done !== 1'b1 || cpu_rst !== 1'b0) begin
            fails++;
            $display("FAIL done_noise: done=%b rst=%b, required 1 0", load_done, cpu_rst);
        end
        send_byte(8'hA5, 0);
        tests++;
        if (cpu_rst !== 1'b1 || load_done !== 1'b0) begin
            fails++;
            $display("FAIL restart_sync: rst=%b done=%b, required 1 0", cpu_rst, load_done);
        end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        tests++;
        if (load_done !== 1'b1 || cpu_rst !== 1'b0 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL zero_count: done=%b rst=%b err=%b, required 1 0 0", load_done, cpu_rst, load_err);
        end
    endtask

    task automatic test_bad_chk();
        start_frame(11'd1, 0);
        send_word(8'h30, 8'h05, 0);
        send_byte(8'h00, 0);
        tests++;
        if (load_err !== 1'b1 || cpu_rst !== 1'b1 || load_done !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL bad_chk: err=%b rst=%b done=%b pending=%0d, required 1 1 0 0",
                     load_err, cpu_rst, load_done, exp_q.size());
        end
    endtask

    task automatic test_bad_hi();
        start_frame(11'd1, 0);
        send_byte(8'hC0, 0);
        tests++;
        if (load_err !== 1'b1 || cpu_rst !== 1'b1) begin
            fails++;
            $display("FAIL bad_hi: err=%b rst=%b, required 1 1", load_err, cpu_rst);
        end
        send_byte(8'h05, 0);
        send_byte(8'h35, 0);
        repeat (2) tick();
        frame_one(0);
        tests++;
        if (load_done !== 1'b1 || load_err !== 1'b0 || cpu_rst !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL err_recover: done=%b err=%b rst=%b pending=%0d, required 1 0 0 0",
                     load_done, load_err, cpu_rst, exp_q.size());
        end
    endtask

    task automatic test_bad_cnt();
        send_byte(8'hA5, 0);
        send_byte(8'h08, 0);
        tests++;
        if (load_err !== 1'b1 || cpu_rst !== 1'b1 || load_done !== 1'b0) begin
            fails++;
            $display("FAIL bad_cnt: err=%b rst=%b done=%b, required 1 1 0", load_err, cpu_rst, load_done);
        end
        send_byte(8'h00, 0);
        tests++;
        if (load_err !== 1'b1) begin
            fails++;
            $display("FAIL err_hold: err=%b, required 1", load_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] hi;
        logic [7:0] lo;
        start_frame(11'd5, 0);
        for (int i = 0; i < 5; i++) begin
            hi = 8'($urandom_range(0, 63));
            lo = 8'($urandom_range(0, 255));
            send_word(hi, lo, 0);
        end
        send_byte(chk_acc, 0);
        tests++;
        if (load_done !== 1'b1 || cpu_rst !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL random_frame: done=%b rst=%b pending=%0d, required 1 0 0",
                     load_done, cpu_rst, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_and_gaps();
        start_frame(11'd2, 0);
        send_word(8'h30, 8'h05, 0);
        send_byte(8'h3E, 0);
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 11'd0 || mem_wdata !== 14'd0 ||
            cpu_rst !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: rdy=%b we=%b addr=%h data=%h rst=%b done=%b err=%b, required 1 0 0 0 1 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, load_done, load_err);
        end
        tick();
        reset_n = 1'b1;
        tick();
        frame_one(3);
        tests++;
        if (load_done !== 1'b1 || cpu_rst !== 1'b0 || load_err !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL gap_frame: done=%b rst=%b err=%b pending=%0d, required 1 0 0 0",
                     load_done, cpu_rst, load_err, exp_q.size());
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        exp_addr = '0;
        chk_acc  = '0;
        test_reset();
        test_frame_ok();
        test_zero_count();
        test_bad_chk();
        test_bad_hi();
        test_bad_cnt();
        test_back_to_back();
        test_reset_mid_and_gaps();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
